// File: rtl/apb_wrapper_top_if.sv
// apb_wrapper_top_if: user-side request/response bundle for apb_wrapper_top.
//   TRANSFER   : request, high starts/continues an APB transfer
//   address    : byte address of the transfer
//   write_data : write payload
//   write_en   : 1 = write, 0 = read
//   read_data  : registered result of the last completed read
// Modports: master (request driver), slave (the wrapper).
interface apb_wrapper_top_if;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  logic             TRANSFER;
  logic [AddrW-1:0] address;
  logic [DataW-1:0] write_data;
  logic             write_en;
  logic [DataW-1:0] read_data;

  modport master (
    output TRANSFER,
    output address,
    output write_data,
    output write_en,
    input  read_data
  );

  modport slave (
    input  TRANSFER,
    input  address,
    input  write_data,
    input  write_en,
    output read_data
  );
endinterface

// File: rtl/apb_wrapper_top.sv
// apb_wrapper_top: APB master (IDLE/SETUP/ACCESS) driving an internal 64 x 32
// slave memory. Only the request bundle and read result are visible.
//   PCLK    : clock, all state on rising edge
//   PRESETn : synchronous active-low reset
//   bus     : apb_wrapper_top_if.slave (TRANSFER, address, write_data,
//             write_en in; read_data out)
// Build option: define APB_WAIT_STATE_EN to make the slave insert one wait
// state (PREADY low on the first ACCESS cycle of every transfer).
module apb_wrapper_top (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  apb_wrapper_top_if.slave         bus
);

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned Depth = 64;
  localparam int unsigned IdxW  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] paddr_q, paddr_d;
  logic [DataW-1:0] pwdata_q, pwdata_d;
  logic             pwrite_q, pwrite_d;
  logic [DataW-1:0] read_data_q, read_data_d;
  logic [DataW-1:0] mem_q [Depth];

  logic             psel;
  logic             penable;
  logic             pready;
  logic [DataW-1:0] prdata;
  logic [IdxW-1:0]  mem_idx;
  logic             mem_wr;
  logic             rd_done;
  logic             unused_addr_bits;

  // Word index: only PADDR[7:2] selects, so addresses alias every 256 bytes.
  assign mem_idx          = paddr_q[7:2];
  assign unused_addr_bits = ^{paddr_q[AddrW-1:8], paddr_q[1:0]};

  // APB bus decode from master state.
  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);

  // Slave ready generation.
`ifdef APB_WAIT_STATE_EN
  logic wait_q, wait_d;

  // wait_q marks that the first (stalled) ACCESS cycle has already elapsed.
  always_comb begin
    wait_d = 1'b0;
    if (state_q == ACCESS) begin
      wait_d = ~wait_q;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wait_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign pready = wait_q;
`else
  assign pready = 1'b1;
`endif

  // Master FSM state register and captured request.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  // Next state; request fields are captured only on entry to SETUP so any
  // input change while in ACCESS is ignored.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    unique case (state_q)
      IDLE: begin
        if (bus.TRANSFER) begin
          state_d  = SETUP;
          paddr_d  = bus.address;
          pwdata_d = bus.write_data;
          pwrite_d = bus.write_en;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          if (bus.TRANSFER) begin
            state_d  = SETUP;
            paddr_d  = bus.address;
            pwdata_d = bus.write_data;
            pwrite_d = bus.write_en;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slave memory: cleared by reset, written on a completing write access.
  assign mem_wr = psel & penable & pwrite_q & pready;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_wr) begin
      mem_q[mem_idx] <= pwdata_q;
    end
  end

  // Slave read data: combinational, zero unless a read is selected.
  assign prdata = (psel && !pwrite_q) ? mem_q[mem_idx] : '0;

  // read_data captures PRDATA only when a read completes, otherwise holds.
  assign rd_done = penable & pready & ~pwrite_q;

  always_comb begin
    read_data_d = read_data_q;
    if (rd_done) begin
      read_data_d = prdata;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_apb_wrapper_top.sv
// tb_apb_wrapper_top: scoreboard bench for apb_wrapper_top. Expected read
// results are queued when a read is driven and popped when it completes.
module tb_apb_wrapper_top;

`ifdef APB_WAIT_STATE_EN
  localparam int ACC = 2;
`else
  localparam int ACC = 1;
`endif

  logic PCLK = 1'b0;
  logic PRESETn;

  apb_wrapper_top_if bus ();

  apb_wrapper_top dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] exp_q [$];
  logic [31:0] rd_last;

  // Bus activity counters sampled mid-cycle.
  int pen_cnt    = 0;
  int psel_lo_cnt = 0;

  always @(negedge PCLK) begin
    if (dut.penable) pen_cnt = pen_cnt + 1;
    if (!dut.psel) psel_lo_cnt = psel_lo_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic sb_pop_check(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.read_data, e);
      rd_last = e;
    end
  endtask

  task automatic apply_reset(input int n);
    PRESETn = 1'b0;
    bus.TRANSFER = 1'b0;
    repeat (n) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    rd_last = '0;
    exp_q.delete();
  endtask

  // One transfer; TRANSFER held for hi cycles, inputs scrambled afterwards.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input int hi);
    int pen0;
    pen0 = pen_cnt;
    bus.TRANSFER   = 1'b1;
    bus.write_en   = we;
    bus.address    = addr;
    bus.write_data = data;
    if (we) ref_mem[addr[7:2]] = data;
    else exp_q.push_back(ref_mem[addr[7:2]]);
    @(posedge PCLK); #1;
    bus.address    = ~addr;
    bus.write_data = ~data;
    bus.write_en   = ~we;
    if (hi < 2) bus.TRANSFER = 1'b0;
    @(posedge PCLK); #1;
    bus.TRANSFER = 1'b0;
    repeat (ACC) @(posedge PCLK);
    #1;
    if (we) begin
      check({tag, "_mem"}, dut.mem_q[addr[7:2]], data);
      check({tag, "_rd_hold"}, bus.read_data, rd_last);
    end else begin
      sb_pop_check({tag, "_rd"});
    end
    check({tag, "_pen_cycles"}, 32'(pen_cnt - pen0), 32'(ACC));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pen0;
    int lo0;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;

    PRESETn        = 1'b0;
    bus.TRANSFER   = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    bus.write_en   = 1'b0;

    apply_reset(2);
    check("rst_read_data", bus.read_data, 32'h0);
    check("rst_psel", 32'(dut.psel), 32'h0);
    check("rst_penable", 32'(dut.penable), 32'h0);

    // Write then read, TRANSFER held two cycles on the write.
    xfer("wr_abcd", 1'b1, 32'h4, 32'h0000ABCD, 2);
    repeat (2) @(posedge PCLK);
    #1;
    xfer("rd_abcd", 1'b0, 32'h4, 32'h0, 1);

    // Aliasing modulo 256 bytes.
    xfer("wr_alias", 1'b1, 32'h104, 32'h12345678, 1);
    xfer("rd_alias", 1'b0, 32'h004, 32'h0, 1);

    // Reset after traffic clears memory and read_data.
    xfer("wr_pre_rst", 1'b1, 32'h20, 32'hCAFEF00D, 1);
    apply_reset(2);
    check("rst2_read_data", bus.read_data, 32'h0);
    xfer("rd_after_rst", 1'b0, 32'h4, 32'h0, 1);
    xfer("rd_after_rst20", 1'b0, 32'h20, 32'h0, 1);

    // Back-to-back write then read of the same word without leaving the bus.
    pen0 = pen_cnt;
    bus.TRANSFER   = 1'b1;
    bus.write_en   = 1'b1;
    bus.address    = 32'h8;
    bus.write_data = 32'hDEADBEEF;
    ref_mem[2]     = 32'hDEADBEEF;
    @(posedge PCLK); #1;
    lo0 = psel_lo_cnt;
    @(posedge PCLK); #1;
    bus.write_en   = 1'b0;
    bus.address    = 32'h8;
    bus.write_data = 32'h0;
    exp_q.push_back(ref_mem[2]);
    repeat (ACC) @(posedge PCLK);
    #1;
    @(posedge PCLK); #1;
    bus.TRANSFER = 1'b0;
    repeat (ACC) @(posedge PCLK);
    #1;
    sb_pop_check("b2b_rd");
    check("b2b_psel_low", 32'(psel_lo_cnt - lo0), 32'h0);
    check("b2b_pen_cycles", 32'(pen_cnt - pen0), 32'(2 * ACC));

    // Mid-transfer reset aborts a write.
    xfer("wr_c_pre", 1'b1, 32'hC, 32'h11112222, 1);
    xfer("rd_c_pre", 1'b0, 32'hC, 32'h0, 1);
    bus.TRANSFER   = 1'b1;
    bus.write_en   = 1'b1;
    bus.address    = 32'hC;
    bus.write_data = 32'hFFFFFFFF;
    @(posedge PCLK); #1;
    bus.TRANSFER = 1'b0;
    @(posedge PCLK); #1;
    check("mid_in_access", 32'(dut.penable), 32'h1);
    apply_reset(1);
    check("mid_rst_read_data", bus.read_data, 32'h0);
    check("mid_rst_psel", 32'(dut.psel), 32'h0);
    xfer("rd_c_after", 1'b0, 32'hC, 32'h0, 1);

    // Wait-state pattern (penable cycle count checked inside xfer).
    xfer("wr_55aa", 1'b1, 32'h10, 32'h55AA55AA, 1);
    xfer("rd_55aa", 1'b0, 32'h10, 32'h0, 1);

    // Random traffic over a few words with random alias bits.
    for (int k = 0; k < 16; k++) begin
      a = $urandom;
      a[7:2] = 6'($urandom_range(0, 5));
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      xfer("rnd", w, a, d, 1 + int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_wrapper_top.md
APB_WRAPPER_TOP -- requirements
Module: apb_wrapper_top

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 PCLK  input  1  clock; all state updates on rising edge.
REQ-003 PRESETn  input  1  reset, synchronous, active-low.
REQ-004 TRANSFER  input  1  request; high = start/continue an APB transfer.
REQ-005 address  input  32  byte address of the transfer.
REQ-006 write_data  input  32  data for write transfers.
REQ-007 write_en  input  1  1 = write, 0 = read.
REQ-008 read_data  output  32  registered result of the last completed read.
REQ-009 The block SHALL internally contain an APB master (PSEL, PENABLE, PWRITE, PADDR, PWDATA) and a single APB slave memory (PRDATA, PREADY). Neither is exposed at the ports.

Function
REQ-010 The master SHALL implement the FSM states IDLE, SETUP and ACCESS.
REQ-011 Transitions:
- IDLE -> SETUP when TRANSFER=1, else stay IDLE.
- SETUP -> ACCESS unconditionally.
- ACCESS with PREADY=0 -> stay ACCESS.
- ACCESS with PREADY=1 and TRANSFER=1 -> SETUP (back-to-back).
- ACCESS with PREADY=1 and TRANSFER=0 -> IDLE.
REQ-012 The master SHALL capture address, write_data and write_en into PADDR/PWDATA/PWRITE on every entry to SETUP. These SHALL be held stable through ACCESS; input changes during ACCESS SHALL have no effect.
REQ-013 Bus signals by state:
- PSEL=1 in SETUP and ACCESS, 0 in IDLE.
- PENABLE=1 only in ACCESS.
REQ-014 The slave SHALL be a 64 x 32-bit memory indexed by PADDR[7:2]. PADDR[1:0] and PADDR[31:8] are ignored, so addresses alias modulo 256 bytes.
REQ-015 A write SHALL update mem[PADDR[7:2]] with PWDATA on the rising edge where PSEL & PENABLE & PWRITE & PREADY = 1.
REQ-016 Slave read path:
- PRDATA SHALL be combinational mem[PADDR[7:2]] while PSEL=1 and PWRITE=0, else 0.
- read_data SHALL load PRDATA on the rising edge where a read completes (ACCESS, PREADY=1).
- read_data SHALL hold its value at all other times, including across writes.
REQ-017 Latency:
- Write visible in memory 3 rising edges after TRANSFER is first sampled high (IDLE, SETUP, ACCESS), with zero wait states.
- read_data valid after the same 3 edges.
REQ-018 A read immediately following a write to the same address in back-to-back mode SHALL return the newly written data.
REQ-019 A TRANSFER pulse of one cycle SHALL still complete one full transfer (SETUP then ACCESS).

Reset
REQ-020 While PRESETn=0 at a rising edge:
- FSM -> IDLE.
- PSEL, PENABLE, PWRITE = 0.
- PADDR, PWDATA = 0.
- read_data = 0.
- All 64 memory words = 0.
REQ-021 Reset asserted during SETUP or ACCESS SHALL abort the transfer with no memory update and no read_data update.
REQ-022 Reset SHALL take priority over all other activity.

Configuration
REQ-023 With APB_WAIT_STATE_EN defined, the slave SHALL drive PREADY=0 on the first ACCESS cycle and PREADY=1 on the second, adding exactly one cycle to every transfer (completion on the 4th edge).
REQ-024 With APB_WAIT_STATE_EN undefined, PREADY SHALL be constantly 1 (zero wait states).

Verification
REQ-025 Write then read: write 0x0000ABCD to address 0x4 (TRANSFER high 2 cycles), idle 2 cycles, then read 0x4 -> read_data = 0x0000ABCD.
REQ-026 Reset values: hold PRESETn=0 for 2 cycles after arbitrary traffic, then read 0x4 -> read_data = 0x00000000.
REQ-027 Aliasing: write 0x12345678 to address 0x104, then read 0x004 -> read_data = 0x12345678.
REQ-028 Back-to-back: hold TRANSFER=1, write 0xDEADBEEF to 0x8, then change inputs during ACCESS to read 0x8 -> next ACCESS returns 0xDEADBEEF. PSEL stays high throughout and the FSM never visits IDLE.
REQ-029 Mid-transfer reset: assert PRESETn=0 during ACCESS of a write of 0xFFFFFFFF to 0xC, then read 0xC -> read_data = 0x00000000.
REQ-030 Wait state: with APB_WAIT_STATE_EN defined, a write/read of 0x55AA55AA at 0x10 shows PENABLE high for 2 cycles per transfer -> read_data = 0x55AA55AA.
